// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ISSUE2,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    typedef enum logic [2:0] {
        REQ_MEMW,
        REQ_MEMR,
        REQ_RFW,
        REQ_RFR,
        REQ_IF
    } req_id_e;

    // Destination of a returning SRAM read word.
    typedef enum logic [1:0] {
        TAG_IF,
        TAG_RF1,
        TAG_RF2,
        TAG_MEMR
    } rd_tag_e;

    typedef struct packed {
        logic    vld;
        rd_tag_e tag;
    } rd_slot_t;

    localparam int MEM_CTRL_RD = 1;
    localparam int MEM_CTRL_WR = 0;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

    // Out-of-range latencies are pinned to the nearest supported value.
    function automatic int clamp_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_rd_lat_pipe.sv
// Delay line of {valid, tag} matching the SRAM read latency.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; one slot enters and one leaves every cycle.
module rd_lat_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_vld,
    input  rd_tag_e in_tag,
    output logic    out_vld,
    output rd_tag_e out_tag
);

    rd_slot_t stage_q [DEPTH];
    rd_slot_t stage_d [DEPTH];

    // Shift every cycle; stage 0 takes the slot issued this cycle.
    always_comb begin
        stage_d[0].vld = in_vld;
        stage_d[0].tag = in_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Slot registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_vld = stage_q[DEPTH-1].vld;
    assign out_tag = stage_q[DEPTH-1].tag;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch, regfile and data accesses onto one single-port word SRAM.
// Latency: write pulse at cycle 2, read at 2+MEM_LAT, rf pair read at 3+MEM_LAT.
// Backpressure: requests are held by the requester and wait until the FSM returns to IDLE.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int SRAM_AW = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_valid,
    input  logic               rf_rd_req,
    input  logic [31:0]        rf_addr1,
    input  logic [31:0]        rf_addr2,
    output logic [31:0]        rf_rdata1,
    output logic [31:0]        rf_rdata2,
    output logic               rf_rd_valid,
    input  logic               rf_wr_req,
    input  logic [31:0]        rf_wr_addr,
    input  logic [31:0]        rf_wr_data,
    output logic               rf_wr_done,
    input  logic [1:0]         mem_ctrl,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_done,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic               err_conflict,
    output logic               err_misalign
);

    localparam int LAT = clamp_lat(MEM_LAT);

    arb_state_e         state_q, state_d;
    req_id_e            gnt_q, gnt_d;
    rd_tag_e            tag_q, tag_d;
    logic [SRAM_AW-1:0] addr2_q, addr2_d;
    logic [31:0]        buf1_q, buf1_d;

    logic               sram_en_q, sram_en_d;
    logic               sram_we_q, sram_we_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]        sram_wdata_q, sram_wdata_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        rf_rdata1_q, rf_rdata1_d;
    logic [31:0]        rf_rdata2_q, rf_rdata2_d;
    logic               rf_rd_valid_q, rf_rd_valid_d;
    logic               rf_wr_done_q, rf_wr_done_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               mem_done_q, mem_done_d;
    logic               err_conflict_q, err_conflict_d;
    logic               err_misalign_q, err_misalign_d;

    logic        mem_rd, mem_wr, mem_conf;
    logic        g_vld, g_we, g_mis;
    req_id_e     g_id;
    rd_tag_e     g_tag;
    logic [31:0] g_addr, g_wdata;
    logic        pipe_vld;
    rd_tag_e     pipe_tag;
    logic        unused_addr_bits;

    assign mem_rd   = mem_ctrl[MEM_CTRL_RD] & ~mem_ctrl[MEM_CTRL_WR];
    assign mem_wr   = mem_ctrl[MEM_CTRL_WR] & ~mem_ctrl[MEM_CTRL_RD];
    assign mem_conf = mem_ctrl[MEM_CTRL_WR] &  mem_ctrl[MEM_CTRL_RD];

    // Word index only uses the SRAM-sized slice of each byte address.
    assign unused_addr_bits = ^{g_addr[31:SRAM_AW+2], rf_addr2[31:SRAM_AW+2]};

    // Fixed-priority pick among pending requesters; 2'b11 on mem_ctrl never wins.
    always_comb begin
        g_vld   = 1'b0;
        g_id    = REQ_IF;
        g_we    = 1'b0;
        g_addr  = if_addr;
        g_wdata = mem_wdata;
        g_tag   = TAG_IF;
        g_mis   = 1'b0;
        if (mem_wr) begin
            g_vld = 1'b1; g_id = REQ_MEMW; g_we = 1'b1; g_addr = mem_addr;
        end else if (mem_rd) begin
            g_vld = 1'b1; g_id = REQ_MEMR; g_addr = mem_addr; g_tag = TAG_MEMR;
        end else if (rf_wr_req) begin
            g_vld = 1'b1; g_id = REQ_RFW; g_we = 1'b1; g_addr = rf_wr_addr; g_wdata = rf_wr_data;
        end else if (rf_rd_req) begin
            g_vld = 1'b1; g_id = REQ_RFR; g_addr = rf_addr1; g_tag = TAG_RF1;
            g_mis = is_misaligned(rf_addr2);
        end else if (if_req) begin
            g_vld = 1'b1; g_id = REQ_IF; g_addr = if_addr;
        end
        g_mis = g_vld & (g_mis | is_misaligned(g_addr));
    end

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        tag_d          = tag_q;
        addr2_d        = addr2_q;
        buf1_d         = buf1_q;
        sram_en_d      = 1'b0;
        sram_we_d      = 1'b0;
        sram_addr_d    = sram_addr_q;
        sram_wdata_d   = sram_wdata_q;
        if_rdata_d     = if_rdata_q;
        if_valid_d     = 1'b0;
        rf_rdata1_d    = rf_rdata1_q;
        rf_rdata2_d    = rf_rdata2_q;
        rf_rd_valid_d  = 1'b0;
        rf_wr_done_d   = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        mem_done_d     = 1'b0;
        err_conflict_d = err_conflict_q | mem_conf;
        err_misalign_d = err_misalign_q;

        // The first word of an rf pair can land while the second is still issuing.
        if (pipe_vld && pipe_tag == TAG_RF1) begin
            buf1_d = sram_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (g_vld) begin
                    state_d        = ST_ISSUE;
                    gnt_d          = g_id;
                    tag_d          = g_tag;
                    addr2_d        = rf_addr2[SRAM_AW+1:2];
                    sram_en_d      = 1'b1;
                    sram_we_d      = g_we;
                    sram_addr_d    = g_addr[SRAM_AW+1:2];
                    sram_wdata_d   = g_wdata;
                    err_misalign_d = err_misalign_q | g_mis;
                end
            end
            ST_ISSUE: begin
                if (gnt_q == REQ_RFR) begin
                    state_d     = ST_ISSUE2;
                    sram_en_d   = 1'b1;
                    sram_addr_d = addr2_q;
                    tag_d       = TAG_RF2;
                end else if (gnt_q == REQ_MEMW) begin
                    state_d    = ST_RESP;
                    mem_done_d = 1'b1;
                end else if (gnt_q == REQ_RFW) begin
                    state_d      = ST_RESP;
                    rf_wr_done_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE2: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pipe_vld && pipe_tag != TAG_RF1) begin
                    state_d = ST_RESP;
                    case (pipe_tag)
                        TAG_IF: begin
                            if_rdata_d = sram_rdata;
                            if_valid_d = 1'b1;
                        end
                        TAG_MEMR: begin
                            mem_rdata_d = sram_rdata;
                            mem_done_d  = 1'b1;
                        end
                        TAG_RF2: begin
                            rf_rdata1_d   = buf1_q;
                            rf_rdata2_d   = sram_rdata;
                            rf_rd_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and all port registers; reset abandons any access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            gnt_q          <= REQ_MEMW;
            tag_q          <= TAG_IF;
            addr2_q        <= '0;
            buf1_q         <= '0;
            sram_en_q      <= 1'b0;
            sram_we_q      <= 1'b0;
            sram_addr_q    <= '0;
            sram_wdata_q   <= '0;
            if_rdata_q     <= '0;
            if_valid_q     <= 1'b0;
            rf_rdata1_q    <= '0;
            rf_rdata2_q    <= '0;
            rf_rd_valid_q  <= 1'b0;
            rf_wr_done_q   <= 1'b0;
            mem_rdata_q    <= '0;
            mem_done_q     <= 1'b0;
            err_conflict_q <= 1'b0;
            err_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            tag_q          <= tag_d;
            addr2_q        <= addr2_d;
            buf1_q         <= buf1_d;
            sram_en_q      <= sram_en_d;
            sram_we_q      <= sram_we_d;
            sram_addr_q    <= sram_addr_d;
            sram_wdata_q   <= sram_wdata_d;
            if_rdata_q     <= if_rdata_d;
            if_valid_q     <= if_valid_d;
            rf_rdata1_q    <= rf_rdata1_d;
            rf_rdata2_q    <= rf_rdata2_d;
            rf_rd_valid_q  <= rf_rd_valid_d;
            rf_wr_done_q   <= rf_wr_done_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_done_q     <= mem_done_d;
            err_conflict_q <= err_conflict_d;
            err_misalign_q <= err_misalign_d;
        end
    end

    rd_lat_pipe #(
        .DEPTH (LAT)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst_n   (reset_n),
        .in_vld  (sram_en_q & ~sram_we_q),
        .in_tag  (tag_q),
        .out_vld (pipe_vld),
        .out_tag (pipe_tag)
    );

    assign sram_en      = sram_en_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign if_valid     = if_valid_q;
    assign rf_rdata1    = rf_rdata1_q;
    assign rf_rdata2    = rf_rdata2_q;
    assign rf_rd_valid  = rf_rd_valid_q;
    assign rf_wr_done   = rf_wr_done_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_done     = mem_done_q;
    assign err_conflict = err_conflict_q;
    assign err_misalign = err_misalign_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each on its own SRAM model.
// Latency: n/a.
// Backpressure: requests are held until their pulse, as the core does.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // MEM_LAT=1 instance
    logic        if_req, if_valid, rf_rd_req, rf_rd_valid, rf_wr_req, rf_wr_done, mem_done;
    logic [31:0] if_addr, if_rdata, rf_addr1, rf_addr2, rf_rdata1, rf_rdata2;
    logic [31:0] rf_wr_addr, rf_wr_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_ctrl;
    logic        sram_en, sram_we, err_conflict, err_misalign;
    logic [6:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    // MEM_LAT=3 instance
    logic        b_if_req, b_if_valid, b_rf_rd_req, b_rf_rd_valid, b_rf_wr_req, b_rf_wr_done, b_mem_done;
    logic [31:0] b_if_addr, b_if_rdata, b_rf_addr1, b_rf_addr2, b_rf_rdata1, b_rf_rdata2;
    logic [31:0] b_rf_wr_addr, b_rf_wr_data, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_mem_ctrl;
    logic        b_sram_en, b_sram_we, b_err_conflict, b_err_misalign;
    logic [6:0]  b_sram_addr;
    logic [31:0] b_sram_wdata, b_sram_rdata;

    unified_mem_arbiter #(.MEM_LAT(1), .SRAM_AW(7)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .rf_rd_req(rf_rd_req), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rd_valid(rf_rd_valid),
        .rf_wr_req(rf_wr_req), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_done(rf_wr_done),
        .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .err_conflict(err_conflict), .err_misalign(err_misalign)
    );

    unified_mem_arbiter #(.MEM_LAT(3), .SRAM_AW(7)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .rf_rd_req(b_rf_rd_req), .rf_addr1(b_rf_addr1), .rf_addr2(b_rf_addr2),
        .rf_rdata1(b_rf_rdata1), .rf_rdata2(b_rf_rdata2), .rf_rd_valid(b_rf_rd_valid),
        .rf_wr_req(b_rf_wr_req), .rf_wr_addr(b_rf_wr_addr), .rf_wr_data(b_rf_wr_data), .rf_wr_done(b_rf_wr_done),
        .mem_ctrl(b_mem_ctrl), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_done(b_mem_done),
        .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata),
        .err_conflict(b_err_conflict), .err_misalign(b_err_misalign)
    );

    // SRAM models; a preload port fills them while the arbiters are in reset.
    logic        pl_we, pl_sel;
    logic [6:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem1 [128];
    logic [31:0] mem3 [128];
    logic [31:0] rd1;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (pl_we && !pl_sel) mem1[pl_addr] <= pl_data;
        else if (sram_en && sram_we) mem1[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) rd1 <= mem1[sram_addr];
    end
    assign sram_rdata = rd1;

    always @(posedge clk) begin
        if (pl_we && pl_sel) mem3[pl_addr] <= pl_data;
        else if (b_sram_en && b_sram_we) mem3[b_sram_addr] <= b_sram_wdata;
        p3[0] <= (b_sram_en && !b_sram_we) ? mem3[b_sram_addr] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b_sram_rdata = p3[2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int en_cnt, pulses, mdone_at, wdone_at, fv_at;

    initial begin
        reset_n = 1'b0;
        {if_req, rf_rd_req, rf_wr_req} = '0;
        {if_addr, rf_addr1, rf_addr2, rf_wr_addr, rf_wr_data, mem_addr, mem_wdata} = '0;
        mem_ctrl = 2'b00;
        {b_if_req, b_rf_rd_req, b_rf_wr_req} = '0;
        {b_if_addr, b_rf_addr1, b_rf_addr2, b_rf_wr_addr, b_rf_wr_data, b_mem_addr, b_mem_wdata} = '0;
        b_mem_ctrl = 2'b00;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;

        // Preload: word 4 of the fast SRAM, words 1 and 2 of the slow one.
        tick(1);
        pl_we = 1'b1; pl_sel = 1'b0; pl_addr = 7'd4; pl_data = 32'h0050_0093;
        tick(1);
        pl_sel = 1'b1; pl_addr = 7'd1; pl_data = 32'h0000_0011;
        tick(1);
        pl_addr = 7'd2; pl_data = 32'h0000_0022;
        tick(1);
        pl_we = 1'b0;

        // Reset state
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_err_conflict", err_conflict, 0);
        chk("rst_err_misalign", err_misalign, 0);
        chk("rst_other_outs", |{if_rdata, rf_rdata1, rf_rdata2, rf_rd_valid, rf_wr_done,
                                mem_rdata, mem_done, sram_addr}, 0);
        chk("rst_b_outs", |{b_if_rdata, b_if_valid, b_rf_rdata1, b_rf_rdata2, b_rf_rd_valid,
                            b_rf_wr_done, b_mem_rdata, b_mem_done, b_sram_en, b_sram_we,
                            b_sram_addr, b_err_conflict, b_err_misalign}, 0);
        reset_n = 1'b1;
        tick(1);

        // Fetch of byte 0x10 -> word 4
        if_req = 1'b1; if_addr = 32'h10;
        tick(1);
        chk("if_c1_sram_en", sram_en, 1);
        chk("if_c1_sram_we", sram_we, 0);
        chk("if_c1_sram_addr", sram_addr, 7'd4);
        tick(1);
        chk("if_c2_no_valid", if_valid, 0);
        tick(1);
        chk("if_c3_valid", if_valid, 1);
        chk("if_c3_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        tick(1);
        chk("if_c4_pulse_ends", if_valid, 0);

        // Store 0xDEADBEEF to 0x40, then load it back
        mem_ctrl = 2'b01; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
        tick(1);
        chk("wr_c1_sram_en", sram_en, 1);
        chk("wr_c1_sram_we", sram_we, 1);
        chk("wr_c1_sram_addr", sram_addr, 7'h10);
        chk("wr_c1_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk("wr_c1_no_done", mem_done, 0);
        tick(1);
        chk("wr_c2_done", mem_done, 1);
        chk("wr_c2_sram_en_off", sram_en, 0);
        mem_ctrl = 2'b00;
        tick(1);
        mem_ctrl = 2'b10; mem_addr = 32'h40;
        tick(1);
        chk("rd_c1_sram_we", sram_we, 0);
        tick(2);
        chk("rd_c3_done", mem_done, 1);
        chk("rd_c3_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_ctrl = 2'b00;
        tick(1);

        // Three simultaneous requesters: mem read, rf write, fetch
        if_req = 1'b1; if_addr = 32'h10;
        rf_wr_req = 1'b1; rf_wr_addr = 32'h0C; rf_wr_data = 32'h55;
        mem_ctrl = 2'b10; mem_addr = 32'h40;
        en_cnt = 0; pulses = 0; mdone_at = -1; wdone_at = -1; fv_at = -1;
        for (int c = 1; c <= 14; c++) begin
            tick(1);
            if (sram_en) en_cnt++;
            if (mem_done) begin
                pulses++; if (mdone_at < 0) mdone_at = c; mem_ctrl = 2'b00;
            end
            if (rf_wr_done) begin
                pulses++; if (wdone_at < 0) wdone_at = c; rf_wr_req = 1'b0;
            end
            if (if_valid) begin
                pulses++; if (fv_at < 0) fv_at = c; if_req = 1'b0;
            end
        end
        chk("prio_memr_cycle", mdone_at, 3);
        chk("prio_rfw_cycle", wdone_at, 6);
        chk("prio_if_cycle", fv_at, 10);
        chk("prio_sram_en_count", en_cnt, 3);
        chk("prio_pulse_count", pulses, 3);
        chk("prio_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("prio_if_rdata", if_rdata, 32'h0050_0093);

        // The rf write landed in word 3
        mem_ctrl = 2'b10; mem_addr = 32'h0C;
        tick(3);
        chk("rfw_readback_done", mem_done, 1);
        chk("rfw_readback_data", mem_rdata, 32'h55);
        mem_ctrl = 2'b00;
        tick(1);

        // Illegal mem_ctrl: flagged, never granted
        chk("pre_conf_misalign_clear", err_misalign, 0);
        mem_ctrl = 2'b11; mem_addr = 32'h40;
        en_cnt = 0; pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            tick(1);
            if (sram_en) en_cnt++;
            if (mem_done) pulses++;
        end
        chk("conf_flag", err_conflict, 1);
        chk("conf_no_sram_en", en_cnt, 0);
        chk("conf_no_done", pulses, 0);
        mem_ctrl = 2'b00;
        tick(2);
        chk("conf_sticky", err_conflict, 1);

        // Misaligned load of 0x42 reads word 0x10
        mem_ctrl = 2'b10; mem_addr = 32'h42;
        tick(1);
        chk("mis_flag", err_misalign, 1);
        chk("mis_sram_addr", sram_addr, 7'h10);
        tick(2);
        chk("mis_done", mem_done, 1);
        chk("mis_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_ctrl = 2'b00;
        tick(1);

        // Register-pair read at MEM_LAT=3
        b_rf_rd_req = 1'b1; b_rf_addr1 = 32'h04; b_rf_addr2 = 32'h08;
        tick(1);
        chk("rfr_c1_sram_en", b_sram_en, 1);
        chk("rfr_c1_sram_addr", b_sram_addr, 7'd1);
        tick(1);
        chk("rfr_c2_sram_en", b_sram_en, 1);
        chk("rfr_c2_sram_addr", b_sram_addr, 7'd2);
        tick(1);
        chk("rfr_c3_sram_en_off", b_sram_en, 0);
        tick(2);
        chk("rfr_c5_no_valid", b_rf_rd_valid, 0);
        tick(1);
        chk("rfr_c6_valid", b_rf_rd_valid, 1);
        chk("rfr_c6_rdata1", b_rf_rdata1, 32'h11);
        chk("rfr_c6_rdata2", b_rf_rdata2, 32'h22);
        b_rf_rd_req = 1'b0;
        tick(1);
        chk("rfr_c7_pulse_ends", b_rf_rd_valid, 0);

        // Reset while a fetch waits for SRAM data
        if_req = 1'b1; if_addr = 32'h10;
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("arst_sram_en", sram_en, 0);
        chk("arst_if_valid", if_valid, 0);
        chk("arst_if_rdata", if_rdata, 0);
        chk("arst_mem_rdata", mem_rdata, 0);
        chk("arst_err_flags", {err_conflict, err_misalign}, 0);
        if_req = 1'b0;
        tick(2);
        chk("arst_hold_no_valid", if_valid, 0);
        reset_n = 1'b1;
        tick(1);
        chk("arst_release_no_valid", if_valid, 0);
        if_req = 1'b1; if_addr = 32'h10;
        tick(2);
        chk("post_rst_c2_no_valid", if_valid, 0);
        tick(1);
        chk("post_rst_c3_valid", if_valid, 1);
        chk("post_rst_c3_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Synthesizable memory front-end directly downstream of the core's memory-facing ports. It replaces the behavioural bench memory with a single-port word SRAM. It serialises instruction fetch, register-file reads/writes and data-memory accesses onto that SRAM, using fixed priority and req/done handshakes. Byte addresses from the core map to little-endian 32-bit words.

Parameters:
MEM_LAT, 1, SRAM read latency in cycles from sram_en to valid sram_rdata (legal 1..4)
SRAM_AW, 7, SRAM word-address width (128 words = 512 bytes)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched instruction, held until next fetch response
if_valid  out  1  one-cycle response pulse
rf_rd_req  in  1  register-pair read request
rf_addr1, rf_addr2  in  32 each  register byte addresses
rf_rdata1, rf_rdata2  out  32 each  read values, held
rf_rd_valid  out  1  one-cycle pulse, both values valid
rf_wr_req  in  1  register write request
rf_wr_addr  in  32  write byte address
rf_wr_data  in  32  write value
rf_wr_done  out  1  one-cycle pulse
mem_ctrl  in  2  [1]=read, [0]=write; 2'b11 illegal
mem_addr  in  32  data byte address
mem_wdata  in  32  store data
mem_rdata  out  32  load data, held
mem_done  out  1  one-cycle pulse, read or write complete
sram_en  out  1  SRAM access strobe
sram_we  out  1  SRAM write enable (valid with sram_en)
sram_addr  out  SRAM_AW  word address = byte_addr[SRAM_AW+1:2]
sram_wdata  out  32  write word
sram_rdata  in  32  read word, valid MEM_LAT cycles after sram_en
err_conflict  out  1  sticky: mem_ctrl==2'b11 seen
err_misalign  out  1  sticky: any granted address with [1:0]!=0

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0 and state is IDLE. An in-flight access is abandoned without a response. sram_we drops immediately (asynchronously).
- Handshake: a req (or mem_ctrl bit) is held high until its pulse. The requester drops it in the cycle after the pulse. The arbiter does no arbitration during a pulse cycle.
- Priority, evaluated only in IDLE: mem write > mem read > rf write > rf read > fetch. No fairness is required; the in-order core stalls on its own requests.
- mem_ctrl==2'b11: err_conflict is set, the request is never granted and mem_done never pulses.
- Misaligned address: err_misalign is set, address bits [1:0] are ignored and the access proceeds.
- FSM states: IDLE, ISSUE, ISSUE2, WAIT, RESP.
  - IDLE: grant is registered, go to ISSUE.
  - ISSUE: sram_en=1 for exactly one cycle. Writes go to RESP. Single reads go to WAIT. rf read goes to ISSUE2.
  - ISSUE2: second sram_en for rf_addr2, back-to-back (pipelined SRAM), then WAIT.
  - WAIT: count until the last outstanding sram_rdata is captured, then RESP.
  - RESP: drive the granted port's pulse, then IDLE.
- Read data is captured at the end of cycle issue+MEM_LAT. The rf read captures data1 and data2 on consecutive edges.
- Latency from the request-sampled cycle 0 (MEM_LAT=1):
  - write: sram_en cycle 1, pulse cycle 2
  - single read: pulse cycle 2+MEM_LAT
  - rf read: pulse cycle 3+MEM_LAT
- Output registers if_rdata, rf_rdata1/2 and mem_rdata change only on their own port's response.
- Requests arriving during a busy state wait in place; no request is dropped.

Decomposition:
- Package mem_arb_pkg: FSM state enum; requester-ID enum (MEMW, MEMR, RFW, RFR, IF); MEM_CTRL_RD=1 and MEM_CTRL_WR=0 bit indices; MEM_LAT legal-range constants.
- One sub-module rd_lat_pipe: a MEM_LAT-deep shift register of {valid, tag}. It marks which captured sram_rdata belongs to which destination (IF, RF1, RF2, MEMR).

Test Plan:
- Reset, then if_req with if_addr=0x10 and SRAM word 4 = 0x00500093 -> sram_addr=4 in cycle 1, if_valid in cycle 3, if_rdata=0x00500093 (MEM_LAT=1).
- mem_ctrl=01, mem_addr=0x40, mem_wdata=0xDEADBEEF -> sram_en=sram_we=1 and sram_addr=0x10 in cycle 1, mem_done in cycle 2. A following read of 0x40 returns 0xDEADBEEF.
- if_req, rf_wr_req and mem_ctrl=10 raised in the same cycle -> grant order is mem read, rf write, fetch, with no overlapping sram_en and exactly one pulse each.
- rf_rd_req with addr1=0x04 and addr2=0x08 holding 0x11 and 0x22, MEM_LAT=3 -> sram_en in cycles 1 and 2, rf_rd_valid in cycle 6, rdata1=0x11, rdata2=0x22.
- mem_ctrl=11 -> err_conflict=1 stays set, no sram_en, no mem_done. Then mem_addr=0x42 read -> err_misalign=1 and word 0x10 is returned.
- reset_n low during WAIT of a fetch -> all outputs 0 immediately, no if_valid. A fetch after release completes normally.
